data_memory_arbiter: RTL and testbench



---
 rtl/data_memory_arbiter.sv | 144 ++++++++++++++
 tb/tb_data_memory_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter/sequencer in front of the data memory manager: address load, then read/write strobe, then ack.
// Optional DMA_ADDR_REUSE_EN skips the address load when the granted address is already loaded.
module data_memory_arbiter #(
    parameter int READ_LATENCY   = 1,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_req0,
    input  logic       in_req1,
    input  logic       in_we0,
    input  logic       in_we1,
    input  logic [9:0] in_addr0,
    input  logic [9:0] in_addr1,
    input  logic [7:0] in_data0,
    input  logic [7:0] in_data1,
    output logic       out_ack0,
    output logic       out_ack1,
    output logic [7:0] out_rdata,
    output logic       out_busy,
    output logic       out_mem_addr_write_en,
    output logic [9:0] out_mem_addr,
    output logic       out_mem_write_en,
    output logic       out_mem_read_en,
    output logic [7:0] out_mem_data,
    input  logic [7:0] in_mem_data
);

    typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DONE} state_t;

    localparam logic [2:0] LAST_CNT = 3'(READ_LATENCY - 1);

    state_t      state, state_nx;
    logic        gnt;
    logic        last_gnt;
    logic        lat_we;
    logic [7:0]  lat_data;
    logic [2:0]  cnt;

    logic        any_req;
    logic        win;
    logic        win_we;
    logic [9:0]  win_addr;
    logic [7:0]  win_data;
    logic        reuse_hit;
    logic        acc_we;
    logic [7:0]  acc_data;

    always_comb begin
        any_req = in_req0 | in_req1;
        if (in_req0 && in_req1)
            win = FIXED_PRIORITY ? 1'b0 : ~last_gnt;
        else
            win = in_req1;
        win_we   = win ? in_we1   : in_we0;
        win_addr = win ? in_addr1 : in_addr0;
        win_data = win ? in_data1 : in_data0;
        // Entering ACCESS straight from IDLE must use the live winner, not the latches.
        acc_we   = (state == IDLE) ? win_we   : lat_we;
        acc_data = (state == IDLE) ? win_data : lat_data;
    end

`ifdef DMA_ADDR_REUSE_EN
    logic [9:0] last_addr;
    logic       last_valid;

    assign reuse_hit = last_valid && (last_addr == win_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_addr  <= '0;
            last_valid <= 1'b0;
        end else if (state == ADDR) begin
            last_addr  <= out_mem_addr;
            last_valid <= 1'b1;
        end
    end
`else
    assign reuse_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = reuse_hit ? ACCESS : ADDR;
            ADDR:    state_nx = ACCESS;
            ACCESS:  if (lat_we || cnt == LAST_CNT) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    assign out_busy = (state != IDLE);

    // Strobes are registered from the next state so they line up exactly with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt                   <= 1'b0;
            last_gnt              <= 1'b1;
            lat_we                <= 1'b0;
            lat_data              <= '0;
            cnt                   <= '0;
            out_ack0              <= 1'b0;
            out_ack1              <= 1'b0;
            out_rdata             <= '0;
            out_mem_addr_write_en <= 1'b0;
            out_mem_addr          <= '0;
            out_mem_write_en      <= 1'b0;
            out_mem_read_en       <= 1'b0;
            out_mem_data          <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                gnt      <= win;
                last_gnt <= win;
                lat_we   <= win_we;
                lat_data <= win_data;
            end
            cnt <= (state == ACCESS) ? cnt + 3'd1 : 3'd0;

            out_mem_addr_write_en <= (state_nx == ADDR);
            if (state_nx == ADDR)
                out_mem_addr <= win_addr;

            out_mem_write_en <= (state_nx == ACCESS) && acc_we;
            out_mem_read_en  <= (state_nx == ACCESS) && !acc_we;
            if (state_nx == ACCESS && acc_we)
                out_mem_data <= acc_data;

            if (state == ACCESS && !lat_we && cnt == LAST_CNT)
                out_rdata <= in_mem_data;

            out_ack0 <= (state_nx == DONE) && !gnt;
            out_ack1 <= (state_nx == DONE) && gnt;
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter: table of single transactions plus hand-written
// round-robin / fixed-priority, mid-transaction reset and address-reuse sequences.
module tb_data_memory_arbiter;

    localparam int RL = 2;
`ifdef DMA_ADDR_REUSE_EN
    localparam int REUSE_ON = 1;
`else
    localparam int REUSE_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [9:0] addr0, addr1;
    logic [7:0] data0, data1, mem_rdata;

    logic       ack0, ack1, busy, aw_en, wr_en, rd_en;
    logic [7:0] rdata, m_data;
    logic [9:0] m_addr;

    logic       f_ack0, f_ack1, f_busy, f_aw_en, f_wr_en, f_rd_en;
    logic [7:0] f_rdata, f_m_data;
    logic [9:0] f_m_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_memory_arbiter #(.READ_LATENCY(RL), .FIXED_PRIORITY(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_req0(req0), .in_req1(req1), .in_we0(we0), .in_we1(we1),
        .in_addr0(addr0), .in_addr1(addr1), .in_data0(data0), .in_data1(data1),
        .out_ack0(ack0), .out_ack1(ack1), .out_rdata(rdata), .out_busy(busy),
        .out_mem_addr_write_en(aw_en), .out_mem_addr(m_addr),
        .out_mem_write_en(wr_en), .out_mem_read_en(rd_en),
        .out_mem_data(m_data), .in_mem_data(mem_rdata)
    );

    data_memory_arbiter #(.READ_LATENCY(RL), .FIXED_PRIORITY(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .in_req0(req0), .in_req1(req1), .in_we0(we0), .in_we1(we1),
        .in_addr0(addr0), .in_addr1(addr1), .in_data0(data0), .in_data1(data1),
        .out_ack0(f_ack0), .out_ack1(f_ack1), .out_rdata(f_rdata), .out_busy(f_busy),
        .out_mem_addr_write_en(f_aw_en), .out_mem_addr(f_m_addr),
        .out_mem_write_en(f_wr_en), .out_mem_read_en(f_rd_en),
        .out_mem_data(f_m_data), .in_mem_data(mem_rdata)
    );

    typedef struct {
        bit         sel;
        bit         we;
        logic [9:0] addr;
        logic [7:0] data;
        logic [7:0] mdata;
        bit         reuse;
        int         ack_cyc;
        logic [7:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts on a negedge with the DUT idle; returns on a negedge with the DUT idle again.
    task automatic do_txn(input vec_t v);
        int  ack_k = 0, aw_k = 0, aw_n = 0, wr_n = 0, rd_n = 0;
        bit  ack_w = 0;
        logic [9:0] aw_a = '0;
        logic [7:0] wr_d = '0;
        bit  skip;
        skip = (REUSE_ON != 0) && v.reuse;
        mem_rdata = v.mdata;
        if (v.sel) begin req1 = 1; we1 = v.we; addr1 = v.addr; data1 = v.data; end
        else       begin req0 = 1; we0 = v.we; addr0 = v.addr; data0 = v.data; end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (aw_en) begin aw_n++; aw_k = k; aw_a = m_addr; end
            if (wr_en) begin wr_n++; wr_d = m_data; end
            if (rd_en) rd_n++;
            if (ack0 || ack1) begin
                ack_k = k; ack_w = ack1;
                chk("busy_at_ack", busy, 1);
                chk("rdata_at_ack", rdata, v.exp_rdata);
                req0 = 0; req1 = 0;
                break;
            end
        end
        chk("ack_cycle", ack_k, v.ack_cyc);
        chk("ack_which", ack_w, v.sel);
        chk("addr_we_count", aw_n, skip ? 0 : 1);
        if (!skip) begin
            chk("addr_we_cycle", aw_k, 1);
            chk("addr_value", aw_a, v.addr);
        end
        if (v.we) begin
            chk("write_en_count", wr_n, 1);
            chk("write_data", wr_d, v.data);
            chk("read_en_count", rd_n, 0);
        end else begin
            chk("read_en_count", rd_n, RL);
            chk("write_en_count", wr_n, 0);
        end
        @(negedge clk);
        chk("rdata_held", rdata, v.exp_rdata);
        chk("ack_pulse_one_cycle", ack0 | ack1, 0);
        chk("idle_after_done", busy, 0);
    endtask

    vec_t tbl[6];
    vec_t v;
    int   fp_sp;
    bit   e0, e1, fe0;

    initial begin
        //            sel we  addr    data   mdata  reuse ack  rdata
        tbl[0] = '{1'b0, 1'b1, 10'h005, 8'hA5, 8'h00, 1'b0, 3,      8'h00};
        tbl[1] = '{1'b1, 1'b0, 10'h005, 8'h00, 8'hA5, 1'b1, 2 + RL - REUSE_ON, 8'hA5};
        tbl[2] = '{1'b0, 1'b0, 10'h3FE, 8'h00, 8'h0C, 1'b0, 2 + RL, 8'h0C};
        tbl[3] = '{1'b1, 1'b1, 10'h3FF, 8'h5A, 8'h77, 1'b0, 3,      8'h0C};
        tbl[4] = '{1'b0, 1'b1, 10'h3FF, 8'h33, 8'h66, 1'b1, 3 - REUSE_ON, 8'h0C};
        tbl[5] = '{1'b1, 1'b0, 10'h000, 8'h00, 8'hFF, 1'b0, 2 + RL, 8'hFF};

        rst_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {ack0, ack1}, 0);
        chk("rst_strobes", {aw_en, wr_en, rd_en}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", m_addr, 0);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) do_txn(tbl[i]);

        // Both requesters held: round-robin alternates starting with 0; fixed priority only grants 0.
        fp_sp = (REUSE_ON != 0) ? 3 : 4;
        req0 = 1; we0 = 1; addr0 = 10'h100; data0 = 8'h11;
        req1 = 1; we1 = 1; addr1 = 10'h200; data1 = 8'h22;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            e0  = (c % 4 == 3) && ((c / 4) % 2 == 0);
            e1  = (c % 4 == 3) && ((c / 4) % 2 == 1);
            fe0 = (c >= 3) && ((c - 3) % fp_sp == 0);
            chk("rr_ack0", ack0, e0);
            chk("rr_ack1", ack1, e1);
            chk("fp_ack0", f_ack0, fe0);
            chk("fp_ack1", f_ack1, 0);
        end
        req0 = 0; req1 = 0;
        @(negedge clk);
        chk("rr_idle", busy, 0);
        chk("fp_idle", f_busy, 0);

        // Reset pulsed during the write strobe: everything drops, no ack.
        req0 = 1; we0 = 1; addr0 = 10'h123; data0 = 8'h44;
        @(negedge clk);
        chk("mr_addr_we", aw_en, 1);
        @(negedge clk);
        chk("mr_write_en", wr_en, 1);
        rst_n = 0;
        #1;
        chk("mr_strobes_dropped", {aw_en, wr_en, rd_en}, 0);
        chk("mr_busy", busy, 0);
        req0 = 0;
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("mr_no_ack", {ack0, ack1}, 0);
        end

        // After reset the same address must load the address register again.
        v = '{1'b0, 1'b1, 10'h123, 8'h44, 8'h00, 1'b0, 3, 8'h00};
        do_txn(v);
        v = '{1'b0, 1'b1, 10'h123, 8'h45, 8'h00, 1'b1, 3 - REUSE_ON, 8'h00};
        do_txn(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
